// File: rtl/hist_readout_ctrl.sv
// Histogram readout sequencer: triggers the calculator, waits for completion
// with a timeout, then streams all result-RAM bins over valid/ready.
// Optional running total / mismatch check is enabled by HIST_CTRL_TOTAL_EN.
module hist_readout_ctrl #(
  parameter int BINS   = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int TMO_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              auto_en,
  input  logic [TMO_W-1:0]  timeout_cycles,
  input  logic              clear_err,
  output logic              calc_flag,
  input  logic              hist_valid,
  output logic [ADDR_W-1:0] hist_addr,
  input  logic [DATA_W-1:0] hist_data,
  output logic [DATA_W-1:0] bin_data,
  output logic [ADDR_W-1:0] bin_idx,
  output logic              bin_valid,
  input  logic              bin_ready,
  output logic              bin_last,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
`ifdef HIST_CTRL_TOTAL_EN
  ,
  input  logic [31:0]       expected_total,
  output logic [31:0]       hist_total,
  output logic              total_mismatch
`endif
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BINS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_READ,
    S_DONE
  } state_t;

  state_t              state;
  logic [TMO_W-1:0]    wait_cnt;
  logic                issue_done;
  logic                inflight;
  logic [ADDR_W-1:0]   inflight_idx;
  logic                skid_valid;
  logic [DATA_W-1:0]   skid_data;
  logic [ADDR_W-1:0]   skid_idx;

  logic                pop;
  logic [1:0]          held;
  logic                issue;

  // Occupancy is taken net of this cycle's handshake so a full-rate stream
  // keeps one read outstanding per emitted bin.
  always_comb begin
    pop   = bin_valid & bin_ready;
    held  = 2'(bin_valid) + 2'(skid_valid) + 2'(inflight) - 2'(pop);
    issue = (state == S_READ) && !issue_done && (held < 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      issue_done   <= 1'b0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
      skid_valid   <= 1'b0;
      skid_data    <= '0;
      skid_idx     <= '0;
      calc_flag    <= 1'b0;
      hist_addr    <= '0;
      bin_data     <= '0;
      bin_idx      <= '0;
      bin_valid    <= 1'b0;
      bin_last     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
`ifdef HIST_CTRL_TOTAL_EN
      hist_total     <= '0;
      total_mismatch <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      inflight <= 1'b0;

      if (issue) begin
        inflight     <= 1'b1;
        inflight_idx <= hist_addr;
        if (hist_addr == LAST_IDX) issue_done <= 1'b1;
        else                       hist_addr  <= hist_addr + ADDR_W'(1);
      end

      // Two-entry buffer: output register plus a skid slot.
      if (!bin_valid || pop) begin
        if (skid_valid) begin
          bin_valid  <= 1'b1;
          bin_data   <= skid_data;
          bin_idx    <= skid_idx;
          bin_last   <= (skid_idx == LAST_IDX);
          skid_valid <= inflight;
          skid_data  <= hist_data;
          skid_idx   <= inflight_idx;
        end else begin
          bin_valid <= inflight;
          bin_last  <= inflight && (inflight_idx == LAST_IDX);
          if (inflight) begin
            bin_data <= hist_data;
            bin_idx  <= inflight_idx;
          end
        end
      end else if (inflight) begin
        skid_valid <= 1'b1;
        skid_data  <= hist_data;
        skid_idx   <= inflight_idx;
      end

`ifdef HIST_CTRL_TOTAL_EN
      if (pop) hist_total <= hist_total + 32'(bin_data);
`endif

      if (clear_err) timeout_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start || auto_en) begin
            state     <= S_ARM;
            calc_flag <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_ARM: begin
          state    <= S_WAIT;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          if (hist_valid) begin
            state      <= S_READ;
            calc_flag  <= 1'b0;
            hist_addr  <= '0;
            issue_done <= 1'b0;
`ifdef HIST_CTRL_TOTAL_EN
            hist_total <= '0;
`endif
          end else if ((timeout_cycles != '0) &&
                       (wait_cnt == timeout_cycles - TMO_W'(1))) begin
            state       <= S_IDLE;
            calc_flag   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TMO_W'(1);
          end
        end
        S_READ: begin
          if (pop && bin_last) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
`ifdef HIST_CTRL_TOTAL_EN
          total_mismatch <= (hist_total != expected_total);
`endif
        end
        default: begin
          state     <= S_IDLE;
          calc_flag <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hist_readout_ctrl.sv
// Self-checking bench for hist_readout_ctrl: scoreboard of expected bins is
// filled when hist_valid is driven and drained by a stream monitor.
module tb_hist_readout_ctrl;
  localparam int BINS   = 256;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int TMO_W  = 24;
  localparam logic [ADDR_W-1:0] LAST = 8'd255;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, auto_en = 1'b0, clear_err = 1'b0;
  logic hist_valid = 1'b0, bin_ready = 1'b0;
  logic [TMO_W-1:0] timeout_cycles = '0;
  logic calc_flag, bin_valid, bin_last, busy, done, timeout_err;
  logic [ADDR_W-1:0] hist_addr, bin_idx;
  logic [DATA_W-1:0] hist_data, bin_data;
`ifdef HIST_CTRL_TOTAL_EN
  logic [31:0] expected_total = '0;
  logic [31:0] hist_total;
  logic        total_mismatch;
`endif

  typedef struct {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  logic [DATA_W-1:0] ram [BINS];
  exp_t exp_q[$];
  int checks = 0, failures = 0, cyc = 0, hs_count = 0;
  longint ram_sum = 0;

  hist_readout_ctrl #(.BINS(BINS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en),
    .timeout_cycles(timeout_cycles), .clear_err(clear_err),
    .calc_flag(calc_flag), .hist_valid(hist_valid), .hist_addr(hist_addr),
    .hist_data(hist_data), .bin_data(bin_data), .bin_idx(bin_idx),
    .bin_valid(bin_valid), .bin_ready(bin_ready), .bin_last(bin_last),
    .busy(busy), .done(done), .timeout_err(timeout_err)
`ifdef HIST_CTRL_TOTAL_EN
    , .expected_total(expected_total), .hist_total(hist_total),
    .total_mismatch(total_mismatch)
`endif
  );

  always #5 clk = ~clk;

  // Result RAM with one cycle read latency.
  always @(posedge clk) hist_data <= ram[hist_addr];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Stream monitor: ordering, stability, last flag and buffer bound.
  initial begin
    logic              prev_stall;
    logic [DATA_W-1:0] p_data;
    logic [ADDR_W-1:0] p_idx;
    logic              p_last;
    exp_t e;
    prev_stall = 1'b0;
    p_data = '0; p_idx = '0; p_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (calc_flag) hs_count = 0;
        if (busy && !calc_flag && !done) begin
          checks++;
          if ((int'(hist_addr) - hs_count) > 2) begin
            failures++;
            $display("FAIL occupancy: issued=%0d handshaken=%0d required held<=2", hist_addr, hs_count);
          end
        end
        if (prev_stall) begin
          checks++;
          if (!bin_valid || bin_data !== p_data || bin_idx !== p_idx || bin_last !== p_last) begin
            failures++;
            $display("FAIL stall_stable: got v=%0b idx=%0d data=%0d last=%0b required v=1 idx=%0d data=%0d last=%0b",
                     bin_valid, bin_idx, bin_data, bin_last, p_idx, p_data, p_last);
          end
        end
        if (bin_valid) begin
          checks++;
          if (bin_last !== (bin_idx == LAST)) begin
            failures++;
            $display("FAIL bin_last: idx=%0d last=%0b", bin_idx, bin_last);
          end
        end
        if (bin_valid && bin_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_bin: got idx=%0d data=%0d required none", bin_idx, bin_data);
          end else begin
            e = exp_q.pop_front();
            if (bin_idx !== e.idx || bin_data !== e.data || bin_last !== e.last) begin
              failures++;
              $display("FAIL bin: got idx=%0d data=%0d last=%0b required idx=%0d data=%0d last=%0b",
                       bin_idx, bin_data, bin_last, e.idx, e.data, e.last);
            end
          end
          hs_count++;
        end
        prev_stall = bin_valid && !bin_ready;
        p_data = bin_data; p_idx = bin_idx; p_last = bin_last;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ram(input int mode);
    ram_sum = 0;
    for (int k = 0; k < BINS; k++) begin
      case (mode)
        0:       ram[k] = 16'(k + 1);
        1:       ram[k] = 16'($urandom);
        default: ram[k] = (k % 2 == 1) ? 16'd1207 : 16'd1193;
      endcase
      ram_sum += longint'(ram[k]);
    end
  endtask

  // Drive one-cycle hist_valid and queue the bins it should produce.
  task automatic pulse_hist;
    exp_t e;
    for (int k = 0; k < BINS; k++) begin
      e.idx = 8'(k); e.data = ram[k]; e.last = (k == BINS - 1);
      exp_q.push_back(e);
    end
    hist_valid = 1'b1;
    tick;
    hist_valid = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!done && n < bound) begin
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    checks++; if (calc_flag !== 1'b0) begin failures++; $display("FAIL reset_calc_flag: got %0b required 0", calc_flag); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b required 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b required 0", done); end
    checks++; if (bin_valid !== 1'b0 || bin_last !== 1'b0) begin failures++; $display("FAIL reset_stream: got v=%0b last=%0b required 0 0", bin_valid, bin_last); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err: got %0b required 0", timeout_err); end
    checks++; if (hist_addr !== '0 || bin_idx !== '0 || bin_data !== '0) begin failures++; $display("FAIL reset_buses: got addr=%0d idx=%0d data=%0d required 0", hist_addr, bin_idx, bin_data); end
    rst = 1'b0;
    tick;
    // hist_valid while idle must not start anything
    hist_valid = 1'b1;
    tick;
    hist_valid = 1'b0;
    repeat (4) tick;
    checks++; if (busy !== 1'b0 || bin_valid !== 1'b0) begin failures++; $display("FAIL idle_hist_valid: got busy=%0b v=%0b required 0 0", busy, bin_valid); end
    $display("test_reset done");
  endtask

  task automatic test_basic;
    int t0, w, n;
    bit calc_ok;
    fill_ram(0);
    bin_ready = 1'b1;
    timeout_cycles = '0;
    t0 = cyc;
    do_start;
    calc_ok = 1'b1;
    for (int i = 1; i < 90; i++) begin
      if (calc_flag !== 1'b1 || busy !== 1'b1) calc_ok = 1'b0;
      tick;
    end
    if (calc_flag !== 1'b1) calc_ok = 1'b0;
    checks++; if (!calc_ok) begin failures++; $display("FAIL basic_calc_high: calc_flag/busy dropped before hist_valid required high T+1..T+90"); end
    w = cyc;
    checks++; if (w - t0 !== 90) begin failures++; $display("FAIL basic_setup: got W-T=%0d required 90", w - t0); end
    pulse_hist;
    checks++; if (calc_flag !== 1'b0 || hist_addr !== '0 || busy !== 1'b1) begin failures++; $display("FAIL basic_read_entry: got calc=%0b addr=%0d busy=%0b required 0 0 1", calc_flag, hist_addr, busy); end
    tick;
    checks++; if (bin_valid !== 1'b0) begin failures++; $display("FAIL basic_w2: got bin_valid=%0b required 0", bin_valid); end
    tick;
    checks++; if (bin_valid !== 1'b1 || bin_idx !== '0 || bin_data !== 16'd1) begin failures++; $display("FAIL basic_first_bin: got v=%0b idx=%0d data=%0d required 1 0 1", bin_valid, bin_idx, bin_data); end
    wait_done(400, n);
    checks++; if (done !== 1'b1 || cyc - w !== 259) begin failures++; $display("FAIL basic_done_time: got done=%0b at W+%0d required 1 at W+259", done, cyc - w); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL basic_all_bins: got %0d left required 0", exp_q.size()); end
    tick;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL basic_idle: got busy=%0b done=%0b required 0 0", busy, done); end
    $display("test_basic done");
  endtask

  task automatic test_backpressure;
    int n;
    bit stayed_idle;
    fill_ram(1);
    timeout_cycles = '0;
    do_start;
    repeat (5) tick;
    pulse_hist;
    n = 0;
    while (!done && n < 3000) begin
      bin_ready = 1'($urandom_range(0, 1));
      start = (n == 100);
      tick;
      n++;
    end
    start = 1'b0;
    bin_ready = 1'b1;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL bp_done: got done=%0b required 1 within bound", done); end
    checks++; if (exp_q.size() !== 0 || hs_count !== BINS) begin failures++; $display("FAIL bp_count: got left=%0d handshakes=%0d required 0 256", exp_q.size(), hs_count); end
    stayed_idle = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) begin
      if (busy !== 1'b0) stayed_idle = 1'b0;
      tick;
    end
    checks++; if (!stayed_idle) begin failures++; $display("FAIL bp_start_ignored: busy rose after done required 0"); end
    $display("test_backpressure done");
  endtask

  task automatic test_timeout;
    int t0, n;
    timeout_cycles = 24'd20;
    t0 = cyc;
    do_start;
    n = 0;
    while (!timeout_err && n < 100) begin tick; n++; end
    checks++; if (timeout_err !== 1'b1 || cyc - t0 !== 22) begin failures++; $display("FAIL timeout_time: got err=%0b at T+%0d required 1 at T+22", timeout_err, cyc - t0); end
    checks++; if (busy !== 1'b0 || calc_flag !== 1'b0) begin failures++; $display("FAIL timeout_idle: got busy=%0b calc=%0b required 0 0", busy, calc_flag); end
    clear_err = 1'b1;
    tick;
    clear_err = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_clear: got %0b required 0", timeout_err); end
    // clear held across the timeout cycle: the set must win
    clear_err = 1'b1;
    do_start;
    n = 0;
    while (busy && n < 100) begin tick; n++; end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_set_wins: got %0b required 1", timeout_err); end
    tick;
    clear_err = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_clear2: got %0b required 0", timeout_err); end
    // timeout disabled, then a normal readout
    timeout_cycles = '0;
    do_start;
    repeat (60) tick;
    checks++; if (busy !== 1'b1 || calc_flag !== 1'b1 || timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_zero: got busy=%0b calc=%0b err=%0b required 1 1 0", busy, calc_flag, timeout_err); end
    fill_ram(0);
    pulse_hist;
    wait_done(400, n);
    checks++; if (done !== 1'b1 || exp_q.size() !== 0) begin failures++; $display("FAIL timeout_restart: got done=%0b left=%0d required 1 0", done, exp_q.size()); end
    tick;
    $display("test_timeout done");
  endtask

  task automatic test_auto;
    int n, low;
    fill_ram(0);
    timeout_cycles = '0;
    auto_en = 1'b1;
    n = 0;
    while (!calc_flag && n < 10) begin tick; n++; end
    repeat (4) tick;
    pulse_hist;
    wait_done(400, n);
    tick;
    checks++; if (busy !== 1'b0 || calc_flag !== 1'b0) begin failures++; $display("FAIL auto_gap: got busy=%0b calc=%0b at D+1 required 0 0", busy, calc_flag); end
    tick;
    checks++; if (busy !== 1'b1 || calc_flag !== 1'b1) begin failures++; $display("FAIL auto_rearm: got busy=%0b calc=%0b at D+2 required 1 1", busy, calc_flag); end
    timeout_cycles = 24'd20;
    n = 0;
    while (calc_flag && n < 100) begin tick; n++; end
    low = 0;
    while (!calc_flag && low < 50) begin tick; low++; end
    checks++; if (low !== 1) begin failures++; $display("FAIL auto_calc_low: got %0d low cycles required 1", low); end
    auto_en = 1'b0;
    n = 0;
    while (busy && n < 100) begin tick; n++; end
    clear_err = 1'b1;
    tick;
    clear_err = 1'b0;
    repeat (3) tick;
    checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL auto_stop: got busy=%0b err=%0b required 0 0", busy, timeout_err); end
    $display("test_auto done");
  endtask

  task automatic test_reset_mid;
    int n;
    bit quiet;
    fill_ram(0);
    bin_ready = 1'b1;
    timeout_cycles = '0;
    do_start;
    repeat (3) tick;
    pulse_hist;
    n = 0;
    while (!(bin_valid && bin_idx == 8'd100) && n < 300) begin tick; n++; end
    checks++; if (bin_idx !== 8'd100) begin failures++; $display("FAIL rst_mid_reach: got idx=%0d required 100", bin_idx); end
    rst = 1'b1;
    #1;
    checks++;
    if (calc_flag !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bin_valid !== 1'b0 || bin_last !== 1'b0 ||
        hist_addr !== '0 || bin_idx !== '0 || bin_data !== '0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got calc=%0b busy=%0b done=%0b v=%0b last=%0b addr=%0d idx=%0d data=%0d required all 0",
               calc_flag, busy, done, bin_valid, bin_last, hist_addr, bin_idx, bin_data);
    end
    exp_q.delete();
    tick;
    tick;
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (done !== 1'b0 || busy !== 1'b0 || bin_valid !== 1'b0) quiet = 1'b0;
      tick;
    end
    checks++; if (!quiet) begin failures++; $display("FAIL rst_mid_no_done: activity after reset required none"); end
    $display("test_reset_mid done");
  endtask

`ifdef HIST_CTRL_TOTAL_EN
  task automatic test_total;
    int n;
    fill_ram(2);
    bin_ready = 1'b1;
    timeout_cycles = '0;
    expected_total = 32'd307200;
    do_start;
    repeat (3) tick;
    pulse_hist;
    wait_done(400, n);
    checks++; if (hist_total !== 32'd307200 || ram_sum != 307200) begin failures++; $display("FAIL total_sum: got %0d required 307200", hist_total); end
    tick;
    checks++; if (total_mismatch !== 1'b0) begin failures++; $display("FAIL total_match: got %0b required 0", total_mismatch); end
    expected_total = 32'd307201;
    do_start;
    repeat (3) tick;
    pulse_hist;
    wait_done(400, n);
    tick;
    checks++; if (total_mismatch !== 1'b1) begin failures++; $display("FAIL total_mismatch: got %0b required 1", total_mismatch); end
    $display("test_total done");
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_timeout;
    test_auto;
    test_reset_mid;
`ifdef HIST_CTRL_TOTAL_EN
    test_total;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hist_readout_ctrl.md
# hist_readout_ctrl

Sequencer for the histogram calculator's CPU-side interface. On software or automatic request it raises the calculator's trigger, waits for the histogram-complete pulse with a timeout, then walks the 256-bin result RAM and streams each bin out over a valid/ready interface. It sits in the `microblaze_clk` domain between the histogram calculator's external read port and downstream consumers such as a CDF/equalisation-LUT builder or a DMA.

## Interface
Parameters:
- `BINS`, 256: number of bins read out per histogram.
- `ADDR_W`, 8: bin address width; `BINS` must equal 2^`ADDR_W`.
- `DATA_W`, 16: bin count width.
- `TMO_W`, 24: timeout counter width.

Ports:
- `clk` in 1: single clock, the CPU/`microblaze_clk` domain.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request for one histogram; sampled in IDLE only.
- `auto_en` in 1: when high, the block re-arms automatically after each DONE.
- `timeout_cycles` in `TMO_W`: maximum WAIT length; 0 disables the timeout.
- `clear_err` in 1: clears `timeout_err`.
- `calc_flag` out 1: trigger to the calculator.
- `hist_valid` in 1: histogram-complete pulse from the calculator.
- `hist_addr` out `ADDR_W`: read address to the result RAM.
- `hist_data` in `DATA_W`: result RAM data, valid one cycle after `hist_addr`.
- `bin_data` out `DATA_W`: streamed bin count.
- `bin_idx` out `ADDR_W`: index of `bin_data`.
- `bin_valid` out 1: stream valid.
- `bin_ready` in 1: stream ready.
- `bin_last` out 1: high with `bin_idx` = `BINS`-1.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: single-cycle pulse at the end of readout.
- `timeout_err` out 1: sticky timeout flag.

## Operation
States:
- IDLE: leave when `start`=1 or `auto_en`=1; go to ARM.
- ARM: one cycle; go to WAIT.
- WAIT: count cycles.
  - `hist_valid`=1: go to READ.
  - Count reaches `timeout_cycles` (when non-zero): set `timeout_err`, go to IDLE.
- READ: issue addresses 0..`BINS`-1.
  - Data is held in a 2-entry output buffer.
  - An address is issued only when buffer occupancy plus reads in flight is less than 2.
  - After the handshake of bin `BINS`-1, go to DONE.
- DONE: one cycle with `done`=1; go to IDLE.

`calc_flag` behaviour:
- Registered; high in ARM and WAIT, low elsewhere.
- IDLE always lasts at least one cycle, so `calc_flag` is low for at least one cycle between requests. This guarantees a rising edge for the calculator's edge detector.

Stream rules:
- A handshake is `bin_valid`&`bin_ready`.
- `bin_data`, `bin_idx` and `bin_last` must stay stable while `bin_valid`=1 and `bin_ready`=0.
- Bins are emitted in strictly ascending index order, with no gaps or duplicates.
- The address counter does not wrap inside one readout. It is reset to 0 on entry to READ.

Ignored inputs:
- `hist_valid` outside WAIT.
- `start` outside IDLE.
- `timeout_err` does not block new requests.
- When `clear_err` and a timeout occur in the same cycle, the set wins.

Reset values, all outputs:
- `calc_flag`, `busy`, `done`, `bin_valid`, `bin_last`, `timeout_err` = 0.
- `hist_addr`, `bin_idx`, `bin_data` = 0.
- State = IDLE, buffer empty.

Asserting `rst` mid-operation aborts immediately: the buffer is emptied and no `done` is produced.

## Timing
- `start` at cycle T: ARM at T+1, `calc_flag` and `busy` high from T+1.
- `hist_valid` at cycle W: READ at W+1, `hist_addr`=0 at W+1, `calc_flag` low from W+1.
- First `bin_valid` at W+3, since RAM latency is 1 plus 1 buffer register.
- With `bin_ready` held high, one bin per cycle; the last bin is at W+258.
  - `done` at W+259.
  - `busy` low from W+260.
- Timeout: `timeout_err` and the return to IDLE happen `timeout_cycles` cycles after WAIT entry.
- With `auto_en`=1, the next ARM follows DONE after exactly one IDLE cycle.

## Configuration
Macro `HIST_CTRL_TOTAL_EN`.

Defined:
- Adds input `expected_total[31:0]` and outputs `hist_total[31:0]` and `total_mismatch`.
- `hist_total` is a 32-bit, non-saturating sum of handshaken bins.
  - It is cleared on READ entry.
  - Its final value is valid in the `done` cycle.
- `total_mismatch` is registered at DONE as `hist_total` != `expected_total` and held until the next DONE.
- All three are 0 at reset.

Undefined:
- The ports are absent and the adder is removed.
- All other behaviour is identical.

## Test plan
- Basic readout. Stimulus: `start` at cycle 10, `hist_valid` at 100, RAM models bin k = k+1, `bin_ready`=1. Required: `calc_flag` high cycles 11–100; bins 0..255 with data 1..256 on cycles 103–358; `bin_last` only at idx 255; `done` at 359.
- Backpressure. Stimulus: `bin_ready` random at 50%. Required: every bin delivered exactly once in order; outputs stable while stalled; no address issued with buffer plus in-flight at 2.
- Timeout. Stimulus: `timeout_cycles`=20, no `hist_valid`. Required: `timeout_err`=1 and back to IDLE 20 cycles after WAIT entry; `clear_err` returns it to 0; a following `start` works.
- Auto mode. Stimulus: `auto_en`=1. Required: `calc_flag` low for exactly one cycle between consecutive requests; a `start` during readout is ignored.
- Reset mid-READ. Stimulus: `rst` at bin 100. Required: all outputs at reset values in the same cycle; no `done`.
- Total check (with `HIST_CTRL_TOTAL_EN` defined). Stimulus: bins summing to 307200 with `expected_total`=307200. Required: `hist_total`=307200, `total_mismatch`=0. Then stimulus with `expected_total`=307201. Required: `total_mismatch`=1.
